// File: rtl/sc_fetch.sv
// sc_fetch: instruction-fetch and PC stage of the single-cycle core.
// It owns the PC, fetches over a req/ack instruction-memory handshake and
// presents one instruction per execute cycle to the decoder and control unit.
// Optional feature macro: SC_FETCH_MISALIGN_TRAP_EN. When it is defined, a
// misaligned next PC is redirected to TRAP_PC and flagged on misalign. When it
// is undefined, the low two bits of the next PC are cleared at commit.

module sc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0080,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic [1:0]  pcsource,
  input  logic [31:0] jr_target,
  input  logic        stall,
  output logic        fetch_err,
  output logic        misalign
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_ERR
  } state_t;

  // Count value held during the last request cycle that is still allowed to
  // see an ack. TIMEOUT is limited to 1..255, so 8 bits never overflow.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic [31:0] commit_pc;
  logic        commit;

  assign pc4    = pc + 32'd4;
  assign br_off = {{14{inst[15]}}, inst[15:0], 2'b00};
  assign commit = (state == S_EXEC) && !stall;

  // Select the candidate next PC from the control unit's pcsource.
  always_comb begin
    next_pc = pc4;
    case (pcsource)
      2'b00:   next_pc = pc4;
      2'b01:   next_pc = pc4 + br_off;
      2'b10:   next_pc = jr_target;
      2'b11:   next_pc = {pc4[31:28], inst[25:0], 2'b00};
      default: next_pc = pc4;
    endcase
  end

`ifdef SC_FETCH_MISALIGN_TRAP_EN
  logic commit_mis;

  // Redirect misaligned targets to the trap vector instead of fetching them.
  always_comb begin
    commit_mis = (next_pc[1:0] != 2'b00);
    commit_pc  = commit_mis ? TRAP_PC : next_pc;
  end

  // Flag raised by a misaligned commit; the next aligned commit clears it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      misalign <= 1'b0;
    end else if (commit) begin
      misalign <= commit_mis;
    end
  end
`else
  logic unused_bits;

  assign commit_pc   = {next_pc[31:2], 2'b00};
  assign misalign    = 1'b0;
  assign unused_bits = ^{TRAP_PC, next_pc[1:0]};
`endif

  // State register; reset drops any fetch in progress straight away.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the state-decoded handshake and status outputs.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    fetch_err  = 1'b0;
    case (state)
      S_IDLE: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_next = S_EXEC;
        end else if (cnt == CNT_LAST) begin
          state_next = S_ERR;
        end
      end
      S_EXEC: begin
        inst_valid = 1'b1;
        if (!stall) begin
          state_next = S_FETCH;
        end
      end
      S_ERR: begin
        fetch_err = 1'b1;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign imem_addr = imem_req ? pc : 32'd0;

  // Registers for the PC, the latched instruction and the fetch timeout count.
  // An ack is only accepted while fetching, so stray acks leave inst alone.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pc   <= RESET_PC;
      inst <= 32'd0;
      cnt  <= 8'd0;
    end else begin
      if (state == S_FETCH) begin
        if (imem_ack) begin
          inst <= imem_rdata;
          cnt  <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= 8'd0;
      end
      if (commit) begin
        pc <= commit_pc;
      end
    end
  end

endmodule

// File: tb/tb_sc_fetch.sv
// tb_sc_fetch: self-checking bench for sc_fetch.
// It uses a table of fetch/commit vectors and a scoreboard of expected
// instructions, followed by hand-written timeout and reset sequences.

module tb_sc_fetch;

  logic        clock = 1'b0;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [1:0]  pcsource;
  logic [31:0] jr_target;
  logic        stall;
  logic        fetch_err;
  logic        misalign;

  always #5 clock = ~clock;

  sc_fetch #(
    .RESET_PC(32'h0000_0000),
    .TRAP_PC (32'h0000_0080),
    .TIMEOUT (16)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .inst      (inst),
    .inst_valid(inst_valid),
    .pc        (pc),
    .pc4       (pc4),
    .pcsource  (pcsource),
    .jr_target (jr_target),
    .stall     (stall),
    .fetch_err (fetch_err),
    .misalign  (misalign)
  );

  typedef struct {
    int          ack_delay;
    int          stall_cycles;
    logic [31:0] rdata;
    logic [1:0]  psel;
    logic [31:0] jr;
    logic [31:0] addr;
    logic [31:0] next_addr;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic exp_mis_now = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Check the execute-cycle outputs against the scoreboard head.
  task automatic checkExec(input string tag, input exp_t e);
    checkOutput({tag, "_valid"}, 32'(inst_valid), 32'd1);
    checkOutput({tag, "_req"}, 32'(imem_req), 32'd0);
    checkOutput({tag, "_inst"}, inst, e.inst);
    checkOutput({tag, "_pc"}, pc, e.pc);
    checkOutput({tag, "_pc4"}, pc4, e.pc + 32'd4);
    checkOutput({tag, "_misalign"}, 32'(misalign), 32'(exp_mis_now));
  endtask

  // Run one fetch/execute/commit transaction described by a vector.
  task automatic applyStimulus(input vec_t v);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (imem_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    checkOutput("req_seen", 32'(seen), 32'd1);
    if (!seen) return;
    checkOutput("fetch_addr", imem_addr, v.addr);
    checkOutput("fetch_no_valid", 32'(inst_valid), 32'd0);
    for (int d = 0; d < v.ack_delay; d++) begin
      @(negedge clock);
      checkOutput("req_held", 32'(imem_req), 32'd1);
      checkOutput("addr_held", imem_addr, v.addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = v.rdata;
    e.pc       = v.addr;
    e.inst     = v.rdata;
    sb.push_back(e);
    @(negedge clock);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    checkExec("exec", e);
    if (v.stall_cycles > 0) begin
      stall     = 1'b1;
      pcsource  = ~v.psel;
      jr_target = ~v.jr;
      for (int s = 0; s < v.stall_cycles; s++) begin
        @(negedge clock);
        checkExec("stall", e);
        if (s == v.stall_cycles - 1) stall = 1'b0;
      end
    end
    pcsource  = v.psel;
    jr_target = v.jr;
    @(negedge clock);
    checkOutput("commit_pc", pc, v.next_addr);
    exp_mis_now = v.mis;
    checkOutput("commit_misalign", 32'(misalign), 32'(exp_mis_now));
    pcsource  = 2'b00;
    jr_target = 32'd0;
  endtask

  initial begin
    int   req_cycles;
    vec_t last;

    // Each vector: ack delay, stall cycles, rdata, pcsource, jr, fetch addr, next pc, misalign.
    vecs[0]  = '{0, 0, 32'h0000_0000, 2'b00, 32'h0,          32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[1]  = '{3, 4, 32'h1111_1111, 2'b00, 32'h0,          32'h0000_0004, 32'h0000_0008, 1'b0};
    vecs[2]  = '{0, 0, 32'h2222_0000, 2'b10, 32'h0000_0100, 32'h0000_0008, 32'h0000_0100, 1'b0};
    vecs[3]  = '{0, 0, 32'h1000_FFFF, 2'b01, 32'h0,          32'h0000_0100, 32'h0000_0100, 1'b0};
    vecs[4]  = '{0, 0, 32'h1000_FFFF, 2'b00, 32'h0,          32'h0000_0100, 32'h0000_0104, 1'b0};
    vecs[5]  = '{1, 0, 32'h1234_0003, 2'b01, 32'h0,          32'h0000_0104, 32'h0000_0114, 1'b0};
    vecs[6]  = '{0, 0, 32'h0000_0000, 2'b10, 32'h3000_0010, 32'h0000_0114, 32'h3000_0010, 1'b0};
    vecs[7]  = '{0, 0, 32'h0800_0040, 2'b11, 32'h0,          32'h3000_0010, 32'h3000_0100, 1'b0};
    vecs[8]  = '{0, 0, 32'h0000_0000, 2'b10, 32'hFFFF_FFFC, 32'h3000_0100, 32'hFFFF_FFFC, 1'b0};
    vecs[9]  = '{0, 0, 32'h1000_8000, 2'b00, 32'h0,          32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    vecs[10] = '{0, 0, 32'h1000_FFFE, 2'b01, 32'h0,          32'h0000_0000, 32'hFFFF_FFFC, 1'b0};
    vecs[11] = '{0, 0, 32'h0BFF_FFFF, 2'b11, 32'h0,          32'hFFFF_FFFC, 32'h0FFF_FFFC, 1'b0};
`ifdef SC_FETCH_MISALIGN_TRAP_EN
    vecs[12] = '{0, 0, 32'h0000_0000, 2'b10, 32'h0000_0206, 32'h0FFF_FFFC, 32'h0000_0080, 1'b1};
    vecs[13] = '{0, 0, 32'h0000_0000, 2'b00, 32'h0,          32'h0000_0080, 32'h0000_0084, 1'b0};
`else
    vecs[12] = '{0, 0, 32'h0000_0000, 2'b10, 32'h0000_0206, 32'h0FFF_FFFC, 32'h0000_0204, 1'b0};
    vecs[13] = '{0, 0, 32'h0000_0000, 2'b00, 32'h0,          32'h0000_0204, 32'h0000_0208, 1'b0};
`endif
    last = '{0, 0, 32'h0000_0ABC, 2'b00, 32'h0, 32'h0000_0000, 32'h0000_0004, 1'b0};

    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    pcsource   = 2'b00;
    jr_target  = 32'd0;
    stall      = 1'b0;
    resetn     = 1'b1;
    #1 resetn  = 1'b0;
    #2;
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_pc4", pc4, 32'h4);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_err", 32'(fetch_err), 32'd0);
    checkOutput("rst_misalign", 32'(misalign), 32'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    #1 checkOutput("idle_no_req", 32'(imem_req), 32'd0);
    @(negedge clock);
    checkOutput("idle_one_cycle", 32'(imem_req), 32'd1);

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);

    // Never acknowledge: expect exactly TIMEOUT request cycles, then the sticky fault.
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req === 1'b1) req_cycles++;
      if (fetch_err === 1'b1) break;
      @(negedge clock);
    end
    checkOutput("timeout_err", 32'(fetch_err), 32'd1);
    checkOutput("timeout_cycles", 32'(req_cycles), 32'd16);
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("err_sticky", 32'(fetch_err), 32'd1);
      checkOutput("err_no_req", 32'(imem_req), 32'd0);
      checkOutput("err_no_valid", 32'(inst_valid), 32'd0);
    end
    imem_ack = 1'b0;

    // Reset out of the error state, then restart at the reset PC.
    resetn = 1'b0;
    #1;
    checkOutput("err_rst_err", 32'(fetch_err), 32'd0);
    checkOutput("err_rst_pc", pc, 32'h0);
    checkOutput("err_rst_inst", inst, 32'h0);
    checkOutput("err_rst_misalign", 32'(misalign), 32'd0);
    exp_mis_now = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    checkOutput("restart_req", 32'(imem_req), 32'd1);
    checkOutput("restart_addr", imem_addr, 32'h0);

    // Reset in the middle of a fetch while an ack is arriving.
    #2;
    imem_ack   = 1'b1;
    imem_rdata = 32'hCAFE_0000;
    resetn     = 1'b0;
    #1 checkOutput("midfetch_req_drop", 32'(imem_req), 32'd0);
    @(negedge clock);
    @(negedge clock);
    imem_ack = 1'b0;
    checkOutput("midfetch_ack_discard", inst, 32'h0);
    resetn = 1'b1;
    applyStimulus(last);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
